// File: rtl/spi_eeprom_cmd_arbiter_if.sv
// rtl/spi_eeprom_cmd_arbiter_if.sv - requester and SPI-master bus bundle for spi_eeprom_cmd_arbiter
interface spi_eeprom_cmd_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   rnw;
  logic [7*NREQ-1:0] addr;
  logic [8*NREQ-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [7:0]        rdata;
  logic              err;
  logic [31:0]       cmd_word;
  logic [31:0]       rsp_word;
  logic              busy;

  modport slave (
    input  req, rnw, addr, wdata, rsp_word,
    output gnt, ack, rdata, err, cmd_word, busy
  );

  modport master (
    output req, rnw, addr, wdata, rsp_word,
    input  gnt, ack, rdata, err, cmd_word, busy
  );
endinterface

// File: rtl/spi_eeprom_cmd_arbiter.sv
// rtl/spi_eeprom_cmd_arbiter.sv - round-robin arbiter building SPI EEPROM command words
// SPI_ARB_TIMEOUT_EN adds a WAIT-state watchdog that completes the transaction with err.
module spi_eeprom_cmd_arbiter #(
  parameter int NREQ           = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                     clk,
  input logic                     rst,
  spi_eeprom_cmd_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, GAP} state_t;

  state_t          state_q, state_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [IW-1:0]   rr_q, rr_n;
  logic            rnw_q, rnw_n;
  logic [6:0]      addr_q, addr_n;
  logic [7:0]      wdata_q, wdata_n;
  logic [7:0]      rdata_q, rdata_n;
  logic [GW-1:0]   gap_q, gap_n;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]     to_q, to_n;
  logic            err_q, err_n;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  logic [6:0]      addr_a  [NREQ];
  logic [7:0]      wdata_a [NREQ];
  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] gnt_c, ack_c;
  logic [31:0]     cmd_c;
  logic            unused_rsp;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.addr[7*g +: 7];
    assign wdata_a[g] = bus.wdata[8*g +: 8];
  end

  assign unused_rsp = ^{bus.rsp_word[30:15], bus.rsp_word[6:0]};

  // Round-robin search: first requester at or above rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    rr_n    = rr_q;
    rnw_n   = rnw_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    gap_n   = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
    to_n    = to_q;
    err_n   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_n   = win;
          rnw_n   = bus.rnw[win];
          addr_n  = addr_a[win];
          wdata_n = wdata_a[win];
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        state_n = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        to_n    = '0;
        err_n   = 1'b0;
`endif
      end
      WAIT: begin
        // Ready takes priority over a watchdog expiry in the same cycle.
        if (bus.rsp_word[31]) begin
          if (rnw_q) rdata_n = bus.rsp_word[14:7];
          state_n = DONE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_q == 16'(TIMEOUT_CYCLES - 1)) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          to_n = to_q + 16'd1;
        end
`endif
      end
      DONE: begin
        rr_n    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        gap_n   = '0;
        state_n = GAP;
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_n = IDLE;
        else                              gap_n   = gap_q + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gap_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      rr_q    <= rr_n;
      rnw_q   <= rnw_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      gap_q   <= gap_n;
`ifdef SPI_ARB_TIMEOUT_EN
      to_q    <= to_n;
      err_q   <= err_n;
`endif
    end
  end

  // Outputs decode from the latched operands only, so requester changes mid-transaction are invisible.
  always_comb begin
    gnt_c = '0;
    ack_c = '0;
    cmd_c = '0;
    if (state_q == ISSUE || state_q == WAIT) begin
      gnt_c[idx_q] = 1'b1;
      cmd_c = {1'b0, 1'b1, rnw_q, 14'b0, (rnw_q ? 8'h00 : wdata_q), addr_q};
    end
    if (state_q == DONE) ack_c[idx_q] = 1'b1;
  end

  assign bus.gnt      = gnt_c;
  assign bus.ack      = ack_c;
  assign bus.cmd_word = cmd_c;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state_q != IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.err      = (state_q == DONE) && err_q;
`else
  assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_spi_eeprom_cmd_arbiter.sv
// tb/tb_spi_eeprom_cmd_arbiter.sv - randomized self-checking bench for spi_eeprom_cmd_arbiter
module tb_spi_eeprom_cmd_arbiter;
  localparam int N   = 2;
  localparam int GAP = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_eeprom_cmd_arbiter_if #(.NREQ(N)) bus ();

  spi_eeprom_cmd_arbiter #(.NREQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         total = 0;
  int         bad   = 0;
  logic [N-1:0] m_req;
  logic       m_rnw   [N];
  logic [6:0] m_addr  [N];
  logic [7:0] m_wdata [N];
  int         m_ptr;
  logic [7:0] m_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      bus.rnw[i]          = m_rnw[i];
      bus.addr[7*i +: 7]  = m_addr[i];
      bus.wdata[8*i +: 8] = m_wdata[i];
    end
    bus.req = m_req;
  endtask

  task automatic set_ops(input int i, input logic r, input logic [6:0] a, input logic [7:0] d);
    m_req[i] = 1'b1; m_rnw[i] = r; m_addr[i] = a; m_wdata[i] = d;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (m_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction

  // Serve the transaction the round-robin rule predicts, then walk the idle gap.
  task automatic serve(input int wait_len, input bit withdraw, input logic [31:0] rsp);
    int exp_i, n;
    logic [N-1:0] oh;
    logic [31:0]  exp_cmd;
    logic [7:0]   exp_rd;
    exp_i = pick();
    oh = '0; oh[exp_i] = 1'b1;
    exp_cmd = {1'b0, 1'b1, m_rnw[exp_i], 14'b0, (m_rnw[exp_i] ? 8'h00 : m_wdata[exp_i]), m_addr[exp_i]};
    exp_rd  = m_rnw[exp_i] ? rsp[14:7] : m_rdata;
    n = 0;
    while (bus.gnt === '0 && n < 20) begin tick(); n++; end
    total++;
    if (bus.gnt !== oh) begin bad++; $display("FAIL grant got=%b exp=%b", bus.gnt, oh); end
    for (int c = 0; c <= wait_len; c++) begin
      total++;
      if (bus.cmd_word !== exp_cmd || bus.gnt !== oh || bus.busy !== 1'b1) begin
        bad++; $display("FAIL cmd_hold cyc=%0d got=%h/%b exp=%h/%b", c, bus.cmd_word, bus.gnt, exp_cmd, oh);
      end
      if (withdraw && c == 1) begin
        m_req[exp_i] = 1'b0;
        m_req[(exp_i + 1) % N] = 1'b1;
        m_addr[exp_i]  = ~m_addr[exp_i];
        m_wdata[exp_i] = ~m_wdata[exp_i];
        drive_ops();
      end
      tick();
    end
    bus.rsp_word = rsp | 32'h8000_0000;
    n = 0;
    while (bus.ack === '0 && n < 8) begin tick(); n++; end
    total++;
    if (n !== 1) begin bad++; $display("FAIL ack_latency got=%0d exp=1", n); end
    total++;
    if (bus.ack !== oh || bus.err !== 1'b0 || bus.gnt !== '0) begin
      bad++; $display("FAIL ack got=%b err=%b gnt=%b exp=%b err=0 gnt=0", bus.ack, bus.err, bus.gnt, oh);
    end
    total++;
    if (bus.rdata !== exp_rd) begin bad++; $display("FAIL rdata got=%h exp=%h", bus.rdata, exp_rd); end
    m_rdata = exp_rd;
    m_ptr = (exp_i + 1) % N;
    m_req[exp_i] = 1'b0;
    drive_ops();
    bus.rsp_word = $urandom & 32'h7FFF_FFFF;
    for (int g = 0; g < GAP; g++) begin
      tick();
      total++;
      if (bus.cmd_word !== 32'h0 || bus.ack !== '0 || bus.gnt !== '0 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL gap cyc=%0d cmd=%h ack=%b gnt=%b busy=%b", g, bus.cmd_word, bus.ack, bus.gnt, bus.busy);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_req = '0;
    drive_ops();
    bus.rsp_word = 32'h0;
    tick(); tick();
    rst = 1'b0;
    m_ptr = 0;
    m_rdata = 8'h00;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin m_rnw[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; end
    rst = 1'b1;
    m_req = '1;
    drive_ops();
    bus.rsp_word = 32'hFFFF_FFFF;
    tick(); tick();
    total++; if (bus.gnt !== '0)       begin bad++; $display("FAIL rst_gnt got=%b exp=0", bus.gnt); end
    total++; if (bus.ack !== '0)       begin bad++; $display("FAIL rst_ack got=%b exp=0", bus.ack); end
    total++; if (bus.rdata !== 8'h00)  begin bad++; $display("FAIL rst_rdata got=%h exp=00", bus.rdata); end
    total++; if (bus.err !== 1'b0)     begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    total++; if (bus.cmd_word !== 0)   begin bad++; $display("FAIL rst_cmd got=%h exp=0", bus.cmd_word); end
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    do_reset();
  endtask

  task automatic test_single_write();
    set_ops(0, 1'b0, 7'h15, 8'hA5);
    drive_ops();
    serve(50, 1'b0, 32'h0000_3F80);
  endtask

  task automatic test_single_read();
    set_ops(1, 1'b1, 7'h7F, 8'h5A);
    drive_ops();
    serve(3, 1'b0, 32'h8000_3F80);
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 1'($urandom), 7'($urandom), 8'($urandom));
    drive_ops();
    for (int t = 0; t < 4; t++) begin
      serve($urandom_range(0, 6), 1'b0, $urandom);
      for (int i = 0; i < N; i++)
        if (!m_req[i]) set_ops(i, 1'($urandom), 7'($urandom), 8'($urandom));
      drive_ops();
    end
    while (bus.busy === 1'b1) tick();
    do_reset();
  endtask

  task automatic test_withdraw();
    set_ops(0, 1'b0, 7'($urandom), 8'($urandom));
    drive_ops();
    serve(6, 1'b1, $urandom);
    set_ops(1, 1'b1, 7'($urandom), 8'($urandom));
    drive_ops();
    serve(2, 1'b0, $urandom);
  endtask

  task automatic test_reset_mid_wait();
    int n;
    set_ops(0, 1'b1, 7'h33, 8'h00);
    drive_ops();
    n = 0;
    while (bus.gnt === '0 && n < 20) begin tick(); n++; end
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    total++;
    if (bus.cmd_word !== 0 || bus.gnt !== '0 || bus.busy !== 1'b0 || bus.ack !== '0 || bus.err !== 1'b0) begin
      bad++; $display("FAIL rst_mid cmd=%h gnt=%b busy=%b ack=%b err=%b", bus.cmd_word, bus.gnt, bus.busy, bus.ack, bus.err);
    end
    rst = 1'b0;
    m_ptr = 0;
    m_rdata = 8'h00;
    serve(4, 1'b0, $urandom);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++)
        if (!m_req[i] && $urandom_range(0, 1) == 1) set_ops(i, 1'($urandom), 7'($urandom), 8'($urandom));
      if (m_req == '0) set_ops($urandom_range(0, N - 1), 1'($urandom), 7'($urandom), 8'($urandom));
      drive_ops();
      serve($urandom_range(0, 12), 1'b0, $urandom);
    end
    m_req = '0;
    drive_ops();
    while (bus.busy === 1'b1) tick();
  endtask

  task automatic test_timeout();
    int n;
    bit saw_ack;
    do_reset();
    set_ops(0, 1'b1, 7'h01, 8'h00);
    drive_ops();
    n = 0;
    while (bus.gnt === '0 && n < 20) begin tick(); n++; end
`ifdef SPI_ARB_TIMEOUT_EN
    n = 0;
    while (bus.ack === '0 && n < 4 * TMO) begin tick(); n++; end
    total++;
    if (n !== TMO + 1) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", n, TMO + 1); end
    total++;
    if (bus.ack !== 2'b01 || bus.err !== 1'b1 || bus.rdata !== m_rdata) begin
      bad++; $display("FAIL timeout_ack ack=%b err=%b rdata=%h exp 01/1/%h", bus.ack, bus.err, bus.rdata, m_rdata);
    end
`else
    saw_ack = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (bus.ack !== '0) saw_ack = 1'b1;
    end
    total++;
    if (bus.busy !== 1'b1 || saw_ack) begin
      bad++; $display("FAIL no_timeout busy=%b saw_ack=%b exp busy=1 saw_ack=0", bus.busy, saw_ack);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_withdraw();
    test_reset_mid_wait();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
